// File: rtl/adder_chunked_nbit.sv
// adder_chunked_nbit: add/sub of a,b (+carry_in, sub) CHUNK_BITS per cycle; outputs sum, overflow, busy, done.
module adder_chunked_nbit #(
  parameter int NUM_BITS   = 16,
  parameter int CHUNK_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                sub,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow,
  output logic                busy,
  output logic                done
);
  localparam int K  = NUM_BITS / CHUNK_BITS;
  localparam int CW = K > 1 ? $clog2(K) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [NUM_BITS-1:0] a_r, b_r, wrk, wrk_n;
  logic [CHUNK_BITS:0] cs;
  logic cy, last;
  always_comb begin
    cs = {1'b0, a_r[cnt*CHUNK_BITS +: CHUNK_BITS]} + {1'b0, b_r[cnt*CHUNK_BITS +: CHUNK_BITS]} + {{CHUNK_BITS{1'b0}}, cy};
    wrk_n = wrk;
    wrk_n[cnt*CHUNK_BITS +: CHUNK_BITS] = cs[CHUNK_BITS-1:0];
    last = cnt == CW'(K - 1);
    state_n = state == BUSY ? (last ? DONE : BUSY) : (start ? BUSY : IDLE);
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      wrk      <= '0;
      cy       <= 1'b0;
      sum      <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= state_n == BUSY;
      done  <= state_n == DONE;
      if (state != BUSY && start) begin
        a_r <= a;
        b_r <= sub ? ~b : b;
        cy  <= sub | carry_in;
        cnt <= '0;
      end else if (state == BUSY) begin
        wrk <= wrk_n;
        cy  <= cs[CHUNK_BITS];
        cnt <= cnt + 1'b1;
        if (last) begin
          sum      <= wrk_n;
          overflow <= cs[CHUNK_BITS];
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_chunked_nbit.sv
// tb_adder_chunked_nbit: directed and randomized checks of adder_chunked_nbit against an arithmetic model.
module tb_adder_chunked_nbit;
  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, sub = 1'b0, carry_in = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic overflow, busy, done;
  int errors = 0, checks = 0;
  adder_chunked_nbit #(.NUM_BITS(16), .CHUNK_BITS(4)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .sub(sub), .a(a), .b(b),
    .carry_in(carry_in), .sum(sum), .overflow(overflow), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  function automatic logic [16:0] model(input logic s, input logic [15:0] x, input logic [15:0] y, input logic c);
    return s ? {1'b0, x} + {1'b0, 16'hFFFF - y} + 17'd1 : {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic s, input logic [15:0] x, input logic [15:0] y, input logic c, input bit rnd);
    logic [16:0] e;
    logic [15:0] held;
    e = model(s, x, y, c);
    held = sum;
    start = 1'b1; sub = s; a = x; b = y; carry_in = c;
    tick;
    for (int i = 1; i <= 4; i++) begin
      chk("busy_high", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      chk("sum_hold", 32'(sum), 32'(held));
      if (rnd) begin
        start = 1'($urandom); sub = 1'($urandom); a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom);
      end else start = 1'b0;
      tick;
    end
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_low", 32'(busy), 32'd0);
    chk("sum", 32'(sum), 32'(e[15:0]));
    chk("overflow", 32'(overflow), 32'(e[16]));
    tick;
    chk("done_once", 32'(done), 32'd0);
    chk("sum_after", 32'(sum), 32'(e[15:0]));
  endtask
  initial begin
    logic [15:0] xa [3], xb [3];
    logic xs [3], xc [3];
    logic [16:0] e;
    int idx;
    tick;
    tick;
    n_rst = 1'b1;
    tick;
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      tick;
      chk("idle_sum", 32'(sum), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
    op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op(1'b0, 16'h1234, 16'h4321, 1'b1, 1'b0);
    op(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b0);
    op(1'b1, 16'h0007, 16'h0005, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) begin
      xs[i] = 1'($urandom); xa[i] = 16'($urandom); xb[i] = 16'($urandom); xc[i] = 1'($urandom);
    end
    start = 1'b1; sub = xs[0]; a = xa[0]; b = xb[0]; carry_in = xc[0];
    tick;
    idx = 0;
    for (int n = 1; n <= 14; n++) begin
      if (n == 5 || n == 10) begin
        sub = xs[n / 5]; a = xa[n / 5]; b = xb[n / 5]; carry_in = xc[n / 5];
      end else begin
        a = 16'($urandom); b = 16'($urandom);
      end
      tick;
      chk("b2b_done", 32'(done), (n == 4 || n == 9 || n == 14) ? 32'd1 : 32'd0);
      if (n == 4 || n == 9 || n == 14) begin
        e = model(xs[idx], xa[idx], xb[idx], xc[idx]);
        chk("b2b_sum", 32'(sum), 32'(e[15:0]));
        chk("b2b_ovf", 32'(overflow), 32'(e[16]));
        idx++;
      end
    end
    start = 1'b0;
    tick;
    chk("b2b_idle", 32'(done), 32'd0);
    op(1'b0, 16'hF0F0, 16'h0F0F, 1'b1, 1'b0);
    start = 1'b1; sub = 1'b0; a = 16'hABCD; b = 16'h1111; carry_in = 1'b0;
    tick;
    start = 1'b0;
    tick;
    tick;
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    tick;
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_busy", 32'(busy), 32'd0);
    end
    op(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
